// File: rtl/mips32_dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response port.
// One outstanding transaction; fixed wait states before each response.
module mips32_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [15:0] txn_q;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        rsp_hs;
    logic        enter_resp;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        wr_en;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign txn_count = txn_q;

    assign accept     = req_valid && req_ready;
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the operation must come straight from the request inputs.
    assign op_we    = (state_q == IDLE) ? req_we    : lat_we;
    assign op_addr  = (state_q == IDLE) ? req_addr  : lat_addr;
    assign op_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;

    assign in_range = (op_addr < 32'(DEPTH));
    assign idx      = op_addr[AW-1:0];
    assign wr_en    = enter_resp && op_we && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            (state_q == WAIT): begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            (state_q == RESP): begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            txn_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (!op_we && in_range) ? mem[idx] : 32'd0;
            end
            if (rsp_hs && (txn_q != 16'hFFFF)) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    // Request fields are captured once; the initiator may change them freely.
    always_ff @(posedge clk1) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // No reset on storage: a reset edge only blocks a pending commit.
    always_ff @(posedge clk1) begin
        if (!reset && wr_en) begin
            mem[idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Scoreboard bench for mips32_dmem_responder: a 2-wait-state instance
// and a zero-wait-state instance with the response side always ready.
module tb_mips32_dmem_responder;

    localparam int W_MAIN = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc++;

    int checks = 0;
    int errors = 0;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] txn_count;

    logic        reset0;
    logic        req_valid0;
    logic        req_ready0;
    logic        req_we0;
    logic [31:0] req_addr0;
    logic [31:0] req_wdata0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;
    logic [15:0] txn_count0;

    exp_t        q[$];
    exp_t        q0[$];
    logic [15:0] exp_txn;

    mips32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W_MAIN)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .txn_count (txn_count)
    );

    mips32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk1      (clk1),
        .reset     (reset0),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_we    (req_we0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (1'b1),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0),
        .txn_count (txn_count0)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk1) begin
        if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h, expected none",
                         rsp_rdata);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    always @(negedge clk1) begin
        if (!reset0 && rsp_valid0 === 1'b1) begin
            exp_t e;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp0: got rdata %h, expected none",
                         rsp_rdata0);
            end else begin
                e = q0.pop_front();
                chk("w0_rsp_rdata", rsp_rdata0, e.rdata);
                chk("w0_rsp_err", 32'(rsp_err0), 32'(e.err));
            end
        end
    end

    // One full transaction on the main instance; call at posedge+1.
    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int hold);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk1);
        while (!req_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{exp_rd, exp_err});
        @(posedge clk1);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hAAAA_0003;
        req_wdata = ~wdata;
        n = 0;
        @(negedge clk1);
        while (!rsp_valid && n < 40) begin
            @(posedge clk1);
            n++;
            @(negedge clk1);
        end
        chk("latency", 32'(n), 32'(W_MAIN));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk1);
                @(negedge clk1);
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_rdata", rsp_rdata, exp_rd);
                chk("bp_err", 32'(rsp_err), 32'(exp_err));
                chk("bp_req_ready", 32'(req_ready), 32'd0);
            end
            @(posedge clk1);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk1);
        end
        @(posedge clk1);
        #1;
        exp_txn = (exp_txn == 16'hFFFF) ? exp_txn : exp_txn + 16'd1;
        @(negedge clk1);
        chk("txn_count", 32'(txn_count), 32'(exp_txn));
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk1);
        #1;
    endtask

    logic [31:0] v_addr [6];
    logic [31:0] v_data [6];
    logic        v_we   [6];
    logic [31:0] v_exp  [6];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc;
        int prev;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        exp_txn    = 16'd0;
        reset0     = 1'b1;
        req_valid0 = 1'b0;
        req_we0    = 1'b0;
        req_addr0  = 32'd0;
        req_wdata0 = 32'd0;

        // zero-wait instance: three stores, then three loads back to back
        v_we[0] = 1; v_addr[0] = 1; v_data[0] = 32'h0000_0101; v_exp[0] = 0;
        v_we[1] = 1; v_addr[1] = 2; v_data[1] = 32'hCAFE_0002; v_exp[1] = 0;
        v_we[2] = 1; v_addr[2] = 3; v_data[2] = 32'h3333_3333; v_exp[2] = 0;
        v_we[3] = 0; v_addr[3] = 2; v_data[3] = 32'h0; v_exp[3] = 32'hCAFE_0002;
        v_we[4] = 0; v_addr[4] = 3; v_data[4] = 32'h0; v_exp[4] = 32'h3333_3333;
        v_we[5] = 0; v_addr[5] = 1; v_data[5] = 32'h0; v_exp[5] = 32'h0000_0101;
        repeat (2) @(posedge clk1);
        #1;
        reset0 = 1'b0;
        req_valid0 = 1'b1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            req_we0    = v_we[i];
            req_addr0  = v_addr[i];
            req_wdata0 = v_data[i];
            n = 0;
            @(negedge clk1);
            while (!req_ready0 && n < 10) begin
                @(negedge clk1);
                n++;
            end
            if (!req_ready0) begin
                checks++;
                errors++;
                $display("FAIL w0_accept_timeout: req_ready0 %b, required 1",
                         req_ready0);
                break;
            end
            q0.push_back('{v_exp[i], 1'b0});
            @(posedge clk1);
            #1;
            acc = cyc;
            if (i > 0) chk("w0_cadence", 32'(acc - prev), 32'd2);
            prev = acc;
            @(negedge clk1);
            chk("w0_valid_next_edge", 32'(rsp_valid0), 32'd1);
        end
        req_valid0 = 1'b0;
        @(posedge clk1);
        #1;
        @(negedge clk1);
        chk("w0_txn_count", 32'(txn_count0), 32'd6);
        chk("w0_q_empty", 32'(q0.size()), 32'd0);

        // reset must win over a request presented during reset
        @(posedge clk1);
        #1;
        reset = 1'b1;
        req_valid = 1'b1;
        @(posedge clk1);
        #1;
        @(posedge clk1);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk1);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        @(posedge clk1);
        #1;

        txn(1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        txn(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        chk("txn_after_two", 32'(txn_count), 32'd2);

        txn(1'b1, 32'd7, 32'h0, 32'd0, 1'b0, 0);
        txn(1'b1, 32'd0, 32'h1111_1111, 32'd0, 1'b0, 0);
        txn(1'b1, 32'd1024, 32'h5555_5555, 32'd0, 1'b1, 0);
        txn(1'b0, 32'd0, 32'd0, 32'h1111_1111, 1'b0, 0);
        txn(1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 0);
        txn(1'b1, 32'd1023, 32'h0BAD_F00D, 32'd0, 1'b0, 0);
        txn(1'b0, 32'd1023, 32'd0, 32'h0BAD_F00D, 1'b0, 0);

        txn(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 4);

        // reset one cycle after accepting a store: the store must vanish
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd7;
        req_wdata = 32'h1234_5678;
        rsp_ready = 1'b1;
        @(negedge clk1);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk1);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk1);
        #1;
        reset = 1'b0;
        exp_txn = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            chk("rw_no_valid", 32'(rsp_valid), 32'd0);
        end
        chk("rw_txn_count", 32'(txn_count), 32'd0);
        @(posedge clk1);
        #1;
        txn(1'b0, 32'd7, 32'd0, 32'd0, 1'b0, 0);

        // saturation
        @(negedge clk1);
        dut.txn_q = 16'hFFFE;
        exp_txn = 16'hFFFE;
        @(posedge clk1);
        #1;
        txn(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        txn(1'b0, 32'd0, 32'd0, 32'h1111_1111, 1'b0, 0);
        txn(1'b1, 32'd9, 32'h9999_0000, 32'd0, 1'b0, 0);
        chk("sat_txn_count", 32'(txn_count), 32'h0000_FFFF);

        repeat (3) @(posedge clk1);
        @(negedge clk1);
        chk("q_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
